// File: rtl/decode_issue_if.sv
// Decode-stage handshake bundle: fetch bundle in, decoded bundle out,
// plus the downstream full indications that form the single flow-control point.
interface decode_issue_if #(
  parameter int FETCH_WIDTH = 4,
  parameter int INFO_W      = 64
);
  logic                          fetch_valid;
  logic                          fetch_ready;
  logic [FETCH_WIDTH-1:0]        fetch_en;
  logic [FETCH_WIDTH*32-1:0]     fetch_inst;
  logic [FETCH_WIDTH*INFO_W-1:0] fetch_info;
  logic                          dec_valid;
  logic [FETCH_WIDTH-1:0]        dec_en;
  logic [FETCH_WIDTH*32-1:0]     dec_inst;
  logic [FETCH_WIDTH*INFO_W-1:0] dec_info;
  logic                          rename_full;
  logic                          dis_full;

  // Frontend/backend side: offers bundles, consumes decode output.
  modport master (
    output fetch_valid, fetch_en, fetch_inst, fetch_info, rename_full, dis_full,
    input  fetch_ready, dec_valid, dec_en, dec_inst, dec_info
  );

  // Decode issue controller side.
  modport slave (
    input  fetch_valid, fetch_en, fetch_inst, fetch_info, rename_full, dis_full,
    output fetch_ready, dec_valid, dec_en, dec_inst, dec_info
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Decode issue controller: DEPTH-entry bundle FIFO with bypass into the
// decode->rename output register, one FSM for stall / redirect flush / commit walk.
// Optional performance counters are enabled with the DEC_ISSUE_PERF_EN macro.
module decode_issue_ctrl #(
  parameter int FETCH_WIDTH = 4,
  parameter int INFO_W      = 64,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  decode_issue_if.slave          bus,
  input  logic                   redirect,
  input  logic                   walk,
  output logic [1:0]             state_o,
  output logic [$clog2(DEPTH):0] count_o
`ifdef DEC_ISSUE_PERF_EN
  ,
  output logic [127:0]           perf_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IW    = FETCH_WIDTH * 32;
  localparam int DW    = FETCH_WIDTH * INFO_W;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_WALK  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                   rdy_en_q;
  logic                   dec_valid_q, dec_valid_d;
  logic [FETCH_WIDTH-1:0] dec_en_q, dec_en_d;
  logic [IW-1:0]          dec_inst_q, dec_inst_d;
  logic [DW-1:0]          dec_info_q, dec_info_d;

  logic [FETCH_WIDTH-1:0] mem_en_q   [DEPTH];
  logic [IW-1:0]          mem_inst_q [DEPTH];
  logic [DW-1:0]          mem_info_q [DEPTH];

  logic stall_s, ready_s, keep_s, clr_s, empty_s, load_s, enq_s, deq_s;

  // Flow control: readiness, acceptance and when the output register may advance.
  always_comb begin
    stall_s = bus.rename_full | bus.dis_full;
    ready_s = rdy_en_q & (count_q < CNT_W'(DEPTH))
            & ((state_q == ST_RUN) | (state_q == ST_STALL))
            & ~redirect & ~walk;
    // Empty bundles are accepted but never stored.
    keep_s  = bus.fetch_valid & ready_s & (|bus.fetch_en);
    clr_s   = redirect | walk;
    empty_s = (count_q == {CNT_W{1'b0}});
    load_s  = ~stall_s | ~dec_valid_q;
  end

  // Output register source select (FIFO head, bypass, or bubble) and FIFO push/pop.
  always_comb begin
    dec_valid_d = dec_valid_q;
    dec_en_d    = dec_en_q;
    dec_inst_d  = dec_inst_q;
    dec_info_d  = dec_info_q;
    enq_s       = 1'b0;
    deq_s       = 1'b0;
    if (clr_s) begin
      dec_valid_d = 1'b0;
      dec_en_d    = {FETCH_WIDTH{1'b0}};
    end else if (load_s) begin
      if (!empty_s) begin
        deq_s       = 1'b1;
        enq_s       = keep_s;
        dec_valid_d = 1'b1;
        dec_en_d    = mem_en_q[rd_ptr_q];
        dec_inst_d  = mem_inst_q[rd_ptr_q];
        dec_info_d  = mem_info_q[rd_ptr_q];
      end else if (keep_s) begin
        dec_valid_d = 1'b1;
        dec_en_d    = bus.fetch_en;
        dec_inst_d  = bus.fetch_inst;
        dec_info_d  = bus.fetch_info;
      end else begin
        dec_valid_d = 1'b0;
        dec_en_d    = {FETCH_WIDTH{1'b0}};
      end
    end else begin
      enq_s = keep_s;
    end
  end

  // FIFO pointer and occupancy update; kill empties the FIFO outright.
  always_comb begin
    if (clr_s) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(enq_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(deq_s);
      count_d  = count_q + CNT_W'(enq_s) - CNT_W'(deq_s);
    end
  end

  // Next-state logic, priority redirect > walk > stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (redirect)                    state_d = ST_FLUSH;
        else if (walk)                   state_d = ST_WALK;
        else if (stall_s && dec_valid_q) state_d = ST_STALL;
        else                             state_d = ST_RUN;
      end
      ST_STALL: begin
        if (redirect)     state_d = ST_FLUSH;
        else if (walk)    state_d = ST_WALK;
        else if (!stall_s) state_d = ST_RUN;
        else              state_d = ST_STALL;
      end
      ST_FLUSH, ST_WALK: begin
        if (redirect)  state_d = ST_FLUSH;
        else if (walk) state_d = ST_WALK;
        else           state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Control and output registers; async reset drops every buffered bundle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      count_q     <= {CNT_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      rdy_en_q    <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_en_q    <= {FETCH_WIDTH{1'b0}};
      dec_inst_q  <= {IW{1'b0}};
      dec_info_q  <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rdy_en_q    <= 1'b1;
      dec_valid_q <= dec_valid_d;
      dec_en_q    <= dec_en_d;
      dec_inst_q  <= dec_inst_d;
      dec_info_q  <= dec_info_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      mem_en_q[wr_ptr_q]   <= bus.fetch_en;
      mem_inst_q[wr_ptr_q] <= bus.fetch_inst;
      mem_info_q[wr_ptr_q] <= bus.fetch_info;
    end
  end

  assign bus.fetch_ready = ready_s;
  assign bus.dec_valid   = dec_valid_q;
  assign bus.dec_en      = dec_en_q;
  assign bus.dec_inst    = dec_inst_q;
  assign bus.dec_info    = dec_info_q;
  assign state_o         = state_q;
  assign count_o         = count_q;

`ifdef DEC_ISSUE_PERF_EN
  logic [31:0] stall_cycles_q, walk_cycles_q, flush_cnt_q, fifo_full_cycles_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
  endfunction

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q     <= 32'd0;
      walk_cycles_q      <= 32'd0;
      flush_cnt_q        <= 32'd0;
      fifo_full_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q     <= sat_inc(stall_cycles_q, state_q == ST_STALL);
      walk_cycles_q      <= sat_inc(walk_cycles_q, state_q == ST_WALK);
      flush_cnt_q        <= sat_inc(flush_cnt_q, redirect);
      fifo_full_cycles_q <= sat_inc(fifo_full_cycles_q, count_q == CNT_W'(DEPTH));
    end
  end

  assign perf_o = {fifo_full_cycles_q, flush_cnt_q, walk_cycles_q, stall_cycles_q};
`endif

endmodule
